// File: rtl/sentinel_key_courier_if.sv
// Handshake and status bundle for the Sentinel key courier.
// The master drives the request, key and lock acknowledge; the slave is the courier itself.
interface sentinel_key_courier_if;
    logic       start;
    logic [7:0] key;
    logic       ack_in;
    logic       tx_out;
    logic       busy;
    logic       granted;
    logic       denied;
    logic [3:0] attempt_cnt;
    logic [7:0] seg_out;

    modport master (
        output start, key, ack_in,
        input  tx_out, busy, granted, denied, attempt_cnt, seg_out
    );

    modport slave (
        input  start, key, ack_in,
        output tx_out, busy, granted, denied, attempt_cnt, seg_out
    );
endinterface

// File: rtl/sentinel_key_courier.sv
// Sentinel key courier: framed serial key transmit with bounded ack/retry and 7-seg status.
// Optional even-parity bit before the stop bit when SENTINEL_PARITY_EN is defined.
module sentinel_key_courier #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned ACK_TIMEOUT  = 64,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sentinel_key_courier_if.slave bus
);

    localparam int unsigned DIV_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    localparam logic [7:0] SEG_BLANK   = 8'hFF;
    localparam logic [7:0] SEG_LOCKED  = 8'hC7;
    localparam logic [7:0] SEG_GRANTED = 8'hC1;
    localparam logic [7:0] SEG_DENIED  = 8'h86;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SENTINEL_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_ACK
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [7:0]       key_q, key_d;
    logic [3:0]       att_q, att_d;
    logic             granted_q, granted_d;
    logic             denied_q, denied_d;
    logic             busy_q, busy_d;
    logic [7:0]       seg_q, seg_d;
    logic             tx_q, tx_d;
    logic             ack_meta_q, ack_sync_q;
    logic             div_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= bus.ack_in;
            ack_sync_q <= ack_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            tmr_q     <= '0;
            key_q     <= '0;
            att_q     <= '0;
            granted_q <= 1'b0;
            denied_q  <= 1'b0;
            busy_q    <= 1'b0;
            seg_q     <= SEG_BLANK;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tmr_q     <= tmr_d;
            key_q     <= key_d;
            att_q     <= att_d;
            granted_q <= granted_d;
            denied_q  <= denied_d;
            busy_q    <= busy_d;
            seg_q     <= seg_d;
            tx_q      <= tx_d;
        end
    end

    assign div_last = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tmr_d     = tmr_q;
        key_d     = key_q;
        att_d     = att_q;
        granted_d = granted_q;
        denied_d  = denied_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    key_d     = bus.key;
                    att_d     = 4'd1;
                    granted_d = 1'b0;
                    denied_d  = 1'b0;
                    div_d     = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                div_d = div_last ? '0 : div_q + 1'b1;
                if (div_last) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                div_d = div_last ? '0 : div_q + 1'b1;
                if (div_last) begin
                    if (bit_q == 3'd7) begin
`ifdef SENTINEL_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef SENTINEL_PARITY_EN
            S_PARITY: begin
                div_d = div_last ? '0 : div_q + 1'b1;
                if (div_last) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                div_d = div_last ? '0 : div_q + 1'b1;
                if (div_last) begin
                    tmr_d   = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // Ack is checked before the timeout so a last-cycle ack still grants.
                if (ack_sync_q) begin
                    granted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (tmr_q == TMR_LAST) begin
                    if (att_q < RETRY_MAX) begin
                        att_d   = att_q + 1'b1;
                        div_d   = '0;
                        state_d = S_START;
                    end else begin
                        denied_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = key_d[bit_d];
`ifdef SENTINEL_PARITY_EN
            S_PARITY: tx_d = ^key_d;
`endif
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
        if (busy_d)         seg_d = SEG_LOCKED;
        else if (granted_d) seg_d = SEG_GRANTED;
        else if (denied_d)  seg_d = SEG_DENIED;
        else                seg_d = SEG_BLANK;
    end

    assign bus.tx_out      = tx_q;
    assign bus.busy        = busy_q;
    assign bus.granted     = granted_q;
    assign bus.denied      = denied_q;
    assign bus.attempt_cnt = att_q;
    assign bus.seg_out     = seg_q;

endmodule

// File: doc/sentinel_key_courier.md
Name: sentinel_key_courier

Overview:
- Initiator side of the Sentinel authorization link: serializes an 8-bit authorization key onto a single-wire framed line toward a remote Sentinel lock.
- Waits for the lock's "verified" acknowledge and retries on timeout, up to a bounded count.
- Reports the outcome on sticky status flags and on an active-low 7-segment glyph using the Sentinel display encoding.
- Sits on the operator/badge side of the perimeter, opposite the lock.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2.
- ACK_TIMEOUT, 64, cycles spent in WAIT_ACK before an attempt is declared failed; legal range >= 1.
- MAX_RETRY, 3, total transmission attempts per start, including the first; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request to send; sampled on the rising clk edge.
- key  in  8  key to transmit; latched when start is accepted.
- ack_in  in  1  asynchronous acknowledge from the lock; high means verified.
- tx_out  out  1  serial line; idles high.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- granted  out  1  sticky; high when the last session was acknowledged.
- denied  out  1  sticky; high when the last session exhausted its retries.
- attempt_cnt  out  4  current or final attempt number, counting from 1.
- seg_out  out  8  {dp,g,f,e,d,c,b,a}, active-low glyph.

Behaviour:
- Clock/reset: single clock domain; rst_n is asynchronous assert, synchronous deassert.
- Reset values: tx_out=1, busy=0, granted=0, denied=0, attempt_cnt=0, seg_out=0xFF, state=IDLE.
- Reset mid-frame: the line returns high immediately; no partial frame resumes.
- Registered outputs: all outputs are registered.
- ack_in synchronization: two-flop synchronizer. Only the synchronized value is used; it is sampled only in WAIT_ACK and ignored in every other state.
- Bit timing: a divider counter runs 0..CLKS_PER_BIT-1 per bit; a bit index runs 0..7.

State machine (IDLE, START, DATA, STOP, WAIT_ACK):
- IDLE: on start=1, latch key into key_hold, set attempt_cnt=1, clear granted/denied, go to START.
  - tx_out falls on the cycle after the accepting edge.
  - start while busy=1 is ignored; it is not queued.
- START: tx_out=0 for CLKS_PER_BIT cycles.
- DATA: key_hold bits 0..7, LSB first, each held CLKS_PER_BIT cycles.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. Total frame = 10*CLKS_PER_BIT cycles (11 with parity).
- WAIT_ACK: tx_out=1; a timeout counter runs from 0.
  - Synchronized ack=1: set granted=1, go to IDLE.
  - Counter reaches ACK_TIMEOUT-1 with no ack and attempt_cnt < MAX_RETRY: increment attempt_cnt, resend key_hold, go to START.
  - Same condition with attempt_cnt == MAX_RETRY: set denied=1, go to IDLE.
  - Ack on the final timeout cycle takes priority over timeout.
- Key changes: changes on key while busy have no effect; every retry resends the latched value.
- Sticky status: granted and denied persist in IDLE until the next accepted start. They are never high together.
- attempt_cnt: holds its final value in IDLE.
- seg_out glyphs:
  - 0xFF: IDLE with no result.
  - 0xC7 'L': any busy state.
  - 0xC1 'U': granted.
  - 0x86 'E': denied.

Optional Feature:
- Macro: SENTINEL_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (^key_hold) for CLKS_PER_BIT cycles, so the frame is 11*CLKS_PER_BIT cycles.
- Undefined: no parity state; the frame is 10*CLKS_PER_BIT cycles. All other behaviour is identical in both builds.

Test Plan (all with CLKS_PER_BIT=4, ACK_TIMEOUT=8, MAX_RETRY=3, parity off unless noted):
- Reset: hold rst_n=0 -> tx_out=1, busy=0, seg_out=0xFF, attempt_cnt=0. Assert rst_n=0 mid-DATA -> tx_out=1 in the same cycle and state IDLE after release.
- Frame shape: start with key=0xB6 -> tx_out = 0 for 4 cycles, then bits 0,1,1,0,1,1,0,1 at 4 cycles each, then 1 for 4 cycles. busy=1 and seg_out=0xC7 throughout.
- Acknowledge: key=0xB6, raise ack_in 3 cycles into WAIT_ACK -> granted=1, seg_out=0xC1, attempt_cnt=1, busy=0. Repeat with ack arriving on the final timeout cycle -> granted=1, no retry.
- Retry exhaustion: never raise ack_in -> three frames sent, each followed by 8 wait cycles. Then denied=1, attempt_cnt=3, seg_out=0x86, granted=0.
- Ignored inputs:
  - start pulse mid-frame -> no restart.
  - key changed to 0x00 during retry 2 -> retried frame still carries 0xB6.
  - ack_in high during DATA and low by WAIT_ACK -> no grant.
- Parity build (SENTINEL_PARITY_EN): key=0xB6 -> parity bit 1 for 4 cycles before the stop bit; frame is 44 cycles. key=0x03 -> parity bit 0.
